adpll_acq_sequencer: RTL

Acquisition and lock sequencer for the all-digital PLL. It owns the integer DCO control code and runs a binary-search style frequency acquisition from the phase detector's `p_up`/`p_down` decisions. It halves the step size on every direction reversal, then tracks with unit steps and declares frequency lock after a run of non-monotonic decisions. It sits between the phase detector and the thermometer decoder/filter that drive the DCO, and optionally re-acquires on loss of lock.

---
 rtl/adpll_acq_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/adpll_acq_sequencer.sv
// Purpose: ADPLL frequency-acquisition / lock sequencer driving the integer DCO code from p_up/p_down decisions.
// Latency: 1 phase_clk cycle from sampled decision to registered code/step/state/flag outputs.
// Backpressure: none; a decision is consumed every cycle (both-high or both-low is a HOLD).
// Optional feature: define ADPLL_LOCK_MONITOR_EN to re-enter SEARCH after UNLOCK_CNT same-direction moves in LOCKED.
module adpll_acq_sequencer #(
    parameter int CODE_MAX   = 128,
    parameter int CODE_INIT  = 32,
    parameter int STEP_INIT  = 4,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 4
) (
    input  logic       phase_clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       p_up,
    input  logic       p_down,
    output logic [7:0] dco_code,
    output logic [4:0] step,
    output logic       freq_lock,
    output logic       acq_busy,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEARCH = 3'd1,
        ST_TRACK  = 3'd2,
        ST_LOCKED = 3'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_code;
    logic [4:0] r_step;
    logic       r_last_vld;
    logic       r_last_inc;
    logic [3:0] r_lock_cnt;
    logic       r_freq_lock;
    logic       r_acq_busy;

    state_t     w_state_nxt;
    logic [7:0] w_code_nxt;
    logic [4:0] w_step_nxt;
    logic       w_last_vld_nxt;
    logic       w_last_inc_nxt;
    logic [3:0] w_lock_cnt_nxt;
    logic [3:0] w_lock_cnt_inc;
    logic       w_move;
    logic [4:0] w_move_step;
    logic       w_load_idle;
    logic       w_forget_dir;
    logic [8:0] w_sum;
    logic [8:0] w_diff;

    logic w_inc;
    logic w_dec;
    logic w_vld;
    logic w_rev;

`ifdef ADPLL_LOCK_MONITOR_EN
    logic [3:0] r_unlock_cnt;
    logic [3:0] w_unlock_cnt_nxt;
    logic [3:0] w_unlock_cnt_inc;
`endif

    // Decision decode: exactly one of p_up/p_down is a move, anything else is HOLD.
    assign w_inc = p_down & ~p_up;
    assign w_dec = p_up & ~p_down;
    assign w_vld = w_inc | w_dec;
    assign w_rev = w_vld & r_last_vld & (w_inc != r_last_inc);

    // Next-state, code arithmetic and counter updates.
    always_comb begin
        w_state_nxt    = r_state;
        w_code_nxt     = r_code;
        w_step_nxt     = r_step;
        w_last_vld_nxt = r_last_vld;
        w_last_inc_nxt = r_last_inc;
        w_lock_cnt_nxt = r_lock_cnt;
        w_lock_cnt_inc = r_lock_cnt + 4'd1;
        w_move         = 1'b0;
        w_move_step    = r_step;
        w_load_idle    = 1'b0;
        w_forget_dir   = 1'b0;
        w_sum          = '0;
        w_diff         = '0;
`ifdef ADPLL_LOCK_MONITOR_EN
        w_unlock_cnt_nxt = r_unlock_cnt;
        w_unlock_cnt_inc = r_unlock_cnt + 4'd1;
`endif

        case (r_state)
            ST_IDLE: begin
                w_load_idle = 1'b1;
                if (enable) begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                w_move = w_vld;
                if (w_rev) begin
                    if (r_step > 5'd1) begin
                        // Halve first, then move by the halved step in the same cycle.
                        w_step_nxt  = r_step >> 1;
                        w_move_step = r_step >> 1;
                    end else begin
                        w_move_step    = 5'd1;
                        w_state_nxt    = ST_TRACK;
                        w_lock_cnt_nxt = 4'd0;
                    end
                end
            end
            ST_TRACK: begin
                w_move      = w_vld;
                w_move_step = 5'd1;
                w_step_nxt  = 5'd1;
                if (!w_vld || w_rev) begin
                    if (w_lock_cnt_inc == 4'(LOCK_CNT)) begin
                        w_state_nxt    = ST_LOCKED;
                        w_lock_cnt_nxt = 4'd0;
`ifdef ADPLL_LOCK_MONITOR_EN
                        w_unlock_cnt_nxt = 4'd0;
`endif
                    end else begin
                        w_lock_cnt_nxt = w_lock_cnt_inc;
                    end
                end else begin
                    w_lock_cnt_nxt = 4'd0;
                end
            end
            ST_LOCKED: begin
                w_move      = w_vld;
                w_move_step = 5'd1;
                w_step_nxt  = 5'd1;
`ifdef ADPLL_LOCK_MONITOR_EN
                if (w_vld && !w_rev) begin
                    if (w_unlock_cnt_inc == 4'(UNLOCK_CNT)) begin
                        // Drifting one way: restart the coarse search from the current code.
                        w_state_nxt      = ST_SEARCH;
                        w_step_nxt       = 5'(STEP_INIT);
                        w_forget_dir     = 1'b1;
                        w_unlock_cnt_nxt = 4'd0;
                    end else begin
                        w_unlock_cnt_nxt = w_unlock_cnt_inc;
                    end
                end else begin
                    w_unlock_cnt_nxt = 4'd0;
                end
`endif
            end
            default: begin
                w_load_idle = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase

        // 9-bit arithmetic so the saturation compare sees the carry / borrow.
        if (w_move) begin
            w_last_vld_nxt = 1'b1;
            w_last_inc_nxt = w_inc;
            if (w_inc) begin
                w_sum = {1'b0, r_code} + {4'd0, w_move_step};
                w_code_nxt = (w_sum > 9'(CODE_MAX)) ? 8'(CODE_MAX) : w_sum[7:0];
            end else begin
                w_diff = {1'b0, r_code} - {4'd0, w_move_step};
                w_code_nxt = ({1'b0, r_code} < {4'd0, w_move_step}) ? 8'd0 : w_diff[7:0];
            end
        end

        if (w_forget_dir) begin
            w_last_vld_nxt = 1'b0;
        end

        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_load_idle = 1'b1;
        end

        if (w_load_idle) begin
            w_code_nxt     = 8'(CODE_INIT);
            w_step_nxt     = 5'(STEP_INIT);
            w_last_vld_nxt = 1'b0;
            w_last_inc_nxt = 1'b0;
            w_lock_cnt_nxt = 4'd0;
`ifdef ADPLL_LOCK_MONITOR_EN
            w_unlock_cnt_nxt = 4'd0;
`endif
        end
    end

    // State and datapath registers; flags decoded from next state so they align with state.
    always_ff @(posedge phase_clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_code      <= 8'(CODE_INIT);
            r_step      <= 5'(STEP_INIT);
            r_last_vld  <= 1'b0;
            r_last_inc  <= 1'b0;
            r_lock_cnt  <= 4'd0;
            r_freq_lock <= 1'b0;
            r_acq_busy  <= 1'b0;
`ifdef ADPLL_LOCK_MONITOR_EN
            r_unlock_cnt <= 4'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_code      <= w_code_nxt;
            r_step      <= w_step_nxt;
            r_last_vld  <= w_last_vld_nxt;
            r_last_inc  <= w_last_inc_nxt;
            r_lock_cnt  <= w_lock_cnt_nxt;
            r_freq_lock <= (w_state_nxt == ST_LOCKED);
            r_acq_busy  <= (w_state_nxt == ST_SEARCH) || (w_state_nxt == ST_TRACK);
`ifdef ADPLL_LOCK_MONITOR_EN
            r_unlock_cnt <= w_unlock_cnt_nxt;
`endif
        end
    end

    assign dco_code  = r_code;
    assign step      = r_step;
    assign freq_lock = r_freq_lock;
    assign acq_busy  = r_acq_busy;
    assign state     = r_state;

endmodule
